// File: rtl/seq_pkg.sv
// Shared opcode, FSM-state and instruction-field definitions for the ROM sequencer.
package seq_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_MOV = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    localparam int OP_HI = 10;
    localparam int OP_LO = 8;
    localparam int IMM_W = 8;

endpackage

// File: rtl/seq_alu.sv
// Combinational accumulator ALU: one result plus carry/borrow and zero flags per opcode.
module seq_alu
    import seq_pkg::*;
#(
    parameter int DATA_W = 12
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] acc,
    input  logic [IMM_W-1:0]  imm,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [3:0]        shamt;
    logic              shift_all;

    always_comb begin
        imm_ext              = '0;
        imm_ext[IMM_W-1:0]   = imm;
        sum                  = {1'b0, acc} + {1'b0, imm_ext};
        // the extra MSB of an unsigned subtract is the borrow
        diff                 = {1'b0, acc} - {1'b0, imm_ext};
        shamt                = imm[3:0];
        shift_all            = (32'(shamt) >= DATA_W);
        result               = acc;
        carry                = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            OP_SUB: begin
                result = diff[DATA_W-1:0];
                carry  = diff[DATA_W];
            end
            OP_AND: result = acc & imm_ext;
            OP_OR:  result = acc | imm_ext;
            OP_MOV: result = imm_ext;
            OP_SHL: result = shift_all ? '0 : (acc << shamt);
            OP_SHR: result = shift_all ? '0 : (acc >> shamt);
            default: result = acc;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/rom_sequencer.sv
// Fetch/execute controller for the program ROM: two cycles per instruction, accumulator datapath.
module rom_sequencer
    import seq_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [10:0]       rom_data,
    output logic [DATA_W-1:0] acc,
    output logic              carry,
    output logic              zero,
    output logic              exec_valid,
    output logic [10:0]       ir
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [10:0]       ir_q, ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;

    logic [2:0]        op;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_zero;

    assign op  = ir_q[OP_HI:OP_LO];
    assign imm = ir_q[IMM_W-1:0];

    seq_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (op),
        .acc    (acc_q),
        .imm    (imm),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (run) state_d = S_FETCH;
            S_FETCH: state_d = S_EXEC;
            S_EXEC:  state_d = run ? S_FETCH : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // datapath updates: IR loads at the end of FETCH, everything else at the end of EXEC
    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        if (state_q == S_FETCH) begin
            ir_d = rom_data;
        end else if (state_q == S_EXEC) begin
            if (op == OP_JMP) begin
                pc_d = imm[ADDR_W-1:0];
            end else begin
                pc_d    = pc_q + ADDR_W'(1);
                acc_d   = alu_result;
                carry_d = alu_carry;
                zero_d  = alu_zero;
            end
        end
    end

    always_comb begin
        exec_valid = (state_q == S_EXEC);
        rom_addr   = pc_q;
        acc        = acc_q;
        carry      = carry_q;
        zero       = zero_q;
        ir         = ir_q;
    end

endmodule

// File: tb/tb_rom_sequencer.sv
// Scoreboard bench for rom_sequencer: negedge-registered ROM model, per-EXEC result checks.
module tb_rom_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [2:0]  rom_addr;
    logic [10:0] rom_data;
    logic [11:0] acc;
    logic        carry;
    logic        zero;
    logic        exec_valid;
    logic [10:0] ir;

    logic [10:0] rom [8];

    typedef struct {
        logic [2:0]  pc;
        logic [11:0] acc;
        logic        c;
        logic        z;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    rom_sequencer #(
        .ADDR_W (3),
        .DATA_W (12)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .acc        (acc),
        .carry      (carry),
        .zero       (zero),
        .exec_valid (exec_valid),
        .ir         (ir)
    );

    always #5 clk = ~clk;

    always @(negedge clk) rom_data <= rom[rom_addr];

    function automatic void push(input logic [2:0] pc, input logic [11:0] a,
                                 input logic c, input logic z);
        exp_t e;
        e.pc  = pc;
        e.acc = a;
        e.c   = c;
        e.z   = z;
        sb.push_back(e);
    endfunction

    task automatic fill_rom(input logic [10:0] w);
        foreach (rom[i]) rom[i] = w;
    endtask

    task automatic do_reset();
        run = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drains n scoreboard entries; called and ended at a negedge.
    task automatic run_execs(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            int waited = 0;
            while (!exec_valid && waited < 40) begin
                @(negedge clk);
                waited++;
            end
            n_cmp++;
            if (!exec_valid) begin
                n_fail++;
                $display("FAIL exec_timeout: no exec_valid within 40 cycles, %0d entries left", sb.size());
                sb.delete();
                return;
            end
            e = sb.pop_front();
            n_cmp++;
            if (rom_addr !== e.pc) begin
                n_fail++;
                $display("FAIL exec_pc: got %0d expected %0d", rom_addr, e.pc);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (acc !== e.acc || carry !== e.c || zero !== e.z) begin
                n_fail++;
                $display("FAIL exec_result pc=%0d: got acc=%h c=%b z=%b expected acc=%h c=%b z=%b",
                         e.pc, acc, carry, zero, e.acc, e.c, e.z);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        fill_rom(11'h400);
        do_reset();
        n_cmp++;
        if (acc !== 12'h000 || carry !== 1'b0 || zero !== 1'b1 || ir !== 11'h000 ||
            exec_valid !== 1'b0 || rom_addr !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got acc=%h c=%b z=%b ir=%h ev=%b pc=%0d expected 000 0 1 000 0 0",
                     acc, carry, zero, ir, exec_valid, rom_addr);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exec_valid !== 1'b0 || rom_addr !== 3'd0) begin
            n_fail++;
            $display("FAIL idle_hold: got ev=%b pc=%0d expected 0 0", exec_valid, rom_addr);
        end
    endtask

    task automatic test_program();
        rom[0] = 11'h400; rom[1] = 11'h070; rom[2] = 11'h10C; rom[3] = 11'h502;
        rom[4] = 11'h400; rom[5] = 11'h080; rom[6] = 11'h080; rom[7] = 11'h400;
        do_reset();
        push(0, 12'd0,   0, 1);
        push(1, 12'd112, 0, 0);
        push(2, 12'd100, 0, 0);
        push(3, 12'd400, 0, 0);
        push(4, 12'd0,   0, 1);
        push(5, 12'd128, 0, 0);
        push(6, 12'd256, 0, 0);
        push(7, 12'd0,   0, 1);
        push(0, 12'd0,   0, 1);
        run = 1'b1;
        run_execs(9);
        run = 1'b0;
    endtask

    task automatic test_sub_borrow();
        fill_rom(11'h704);
        rom[0] = 11'h405; rom[1] = 11'h106; rom[2] = 11'h703; rom[3] = 11'h1FF;
        do_reset();
        push(0, 12'h005, 0, 0);
        push(1, 12'hFFF, 1, 0);
        push(2, 12'hFFF, 1, 0);
        push(3, 12'hF00, 0, 0);
        push(4, 12'hF00, 0, 0);
        push(4, 12'hF00, 0, 0);
        run = 1'b1;
        run_execs(6);
        run = 1'b0;
    endtask

    task automatic test_add_carry();
        logic [12:0] s;
        logic [11:0] a;
        fill_rom(11'h701);
        rom[0] = 11'h4FF; rom[1] = 11'h0FF; rom[2] = 11'h701;
        do_reset();
        a = 12'h0FF;
        push(0, a, 0, 0);
        for (int k = 1; k <= 17; k++) begin
            s = {1'b0, a} + 13'h0FF;
            a = s[11:0];
            push(1, a, s[12], a == 12'h000);
            push(2, a, s[12], a == 12'h000);
        end
        run = 1'b1;
        run_execs(35);
        run = 1'b0;
    endtask

    task automatic test_shift();
        fill_rom(11'h706);
        rom[0] = 11'h4FF; rom[1] = 11'h504; rom[2] = 11'h0FF; rom[3] = 11'h50C;
        rom[4] = 11'h480; rom[5] = 11'h60D; rom[6] = 11'h706;
        do_reset();
        push(0, 12'h0FF, 0, 0);
        push(1, 12'hFF0, 0, 0);
        push(2, 12'h0EF, 1, 0);
        push(3, 12'h000, 0, 1);
        push(4, 12'h080, 0, 0);
        push(5, 12'h000, 0, 1);
        push(6, 12'h000, 0, 1);
        run = 1'b1;
        run_execs(7);
        run = 1'b0;
    endtask

    task automatic test_jmp();
        fill_rom(11'h704);
        rom[0] = 11'h407; rom[1] = 11'h001; rom[2] = 11'h703; rom[3] = 11'h310;
        do_reset();
        push(0, 12'h007, 0, 0);
        push(1, 12'h008, 0, 0);
        push(2, 12'h008, 0, 0);
        push(3, 12'h018, 0, 0);
        push(4, 12'h018, 0, 0);
        run = 1'b1;
        run_execs(5);
        run = 1'b0;
        rom[2] = 11'h702;
        do_reset();
        push(0, 12'h007, 0, 0);
        push(1, 12'h008, 0, 0);
        for (int i = 0; i < 5; i++) push(2, 12'h008, 0, 0);
        run = 1'b1;
        run_execs(7);
        run = 1'b0;
    endtask

    task automatic test_run_control();
        int cnt;
        fill_rom(11'h001);
        do_reset();
        push(0, 12'd1, 0, 0);
        push(1, 12'd2, 0, 0);
        push(2, 12'd3, 0, 0);
        run = 1'b1;
        run_execs(3);
        run = 1'b0;
        push(3, 12'd4, 0, 0);
        run_execs(1);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rom_addr !== 3'd4 || exec_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stop_hold: got pc=%0d ev=%b expected pc=4 ev=0", rom_addr, exec_valid);
            end
            @(negedge clk);
        end
        run = 1'b1;
        cnt = 1;
        while (!exec_valid && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        n_cmp++;
        if (cnt != 3 || rom_addr !== 3'd4) begin
            n_fail++;
            $display("FAIL restart_latency: got %0d cycles at pc=%0d expected 3 cycles at pc=4", cnt, rom_addr);
        end
        push(4, 12'd5, 0, 0);
        run_execs(1);
        run = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        fill_rom(11'h001);
        rom[0] = 11'h464;
        do_reset();
        push(0, 12'd100, 0, 0);
        run = 1'b1;
        run_execs(1);
        @(negedge clk);
        n_cmp++;
        if (exec_valid !== 1'b1 || acc !== 12'd100) begin
            n_fail++;
            $display("FAIL pre_reset_exec: got ev=%b acc=%0d expected ev=1 acc=100", exec_valid, acc);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (acc !== 12'd0 || rom_addr !== 3'd0 || zero !== 1'b1 || carry !== 1'b0 ||
            exec_valid !== 1'b0 || ir !== 11'h000) begin
            n_fail++;
            $display("FAIL mid_exec_reset: got acc=%0d pc=%0d z=%b c=%b ev=%b ir=%h expected 0 0 1 0 0 000",
                     acc, rom_addr, zero, carry, exec_valid, ir);
        end
        @(negedge clk);
        rst = 1'b0;
        push(0, 12'd100, 0, 0);
        push(1, 12'd101, 0, 0);
        run_execs(2);
        run = 1'b0;
    endtask

    initial begin
        fill_rom(11'h400);
        test_reset();
        test_program();
        test_sub_borrow();
        test_add_carry();
        test_shift();
        test_jmp();
        test_run_control();
        test_reset_mid_exec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
